// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_WIDTH : default operand width (HI and LO are each this wide)
//   - mdu_op_e  : op codes driven by EXE on the op port
//   - mdu_state_e : controller state encoding
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One iteration of a restoring radix-2 divide (purely combinational).
//   rem_in/quo_in : partial remainder and dividend/quotient shift register
//   divisor       : unsigned divisor magnitude
//   rem_out/quo_out : state after shifting {rem,quo} left and trial-subtracting
// A zero divisor always "fits", so the quotient fills with ones and the
// remainder ends up equal to the dividend.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // The shifted remainder needs one extra bit before the compare.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        rem_sh = {rem_in, quo_in[WIDTH-1]};
        // Result is always < divisor when taken, so WIDTH bits suffice.
        diff   = rem_sh[WIDTH-1:0] - divisor;
        if (rem_sh >= {1'b0, divisor}) begin
            rem_out = diff;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_sh[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   start, op        : operation request (sampled only in IDLE), op code
//   src1, src2       : rs / rt operands
//   flush            : cancel in-flight operation, no HI/LO write
//   busy             : operation in progress (registered)
//   done             : one-cycle pulse around the HI/LO write
//   hi, lo           : architectural HI/LO
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier that
// skips CALC; divides always iterate.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {upper, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic               psign_q, psign_d; // product/quotient negate
    logic               rsign_q, rsign_d; // remainder negate
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    // Starts are refused on the first edge after reset release so a request
    // held across reset deassertion is never taken.
    logic               run_q;

    logic               sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_fix;
    logic [WIDTH-1:0]   rem_step, quo_step, quo_fix, rem_fix;

`ifdef MDU_FAST_MUL_EN
    logic signed [WIDTH:0]   fa, fb;
    logic        [2*WIDTH-1:0] fprod;
`endif

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .quo_in  (acc_q[WIDTH-1:0]),
        .divisor (opnd_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        // Operand magnitudes; op[0]=0 marks the signed variants.
        sgn_op = ~op[0];
        a_neg  = sgn_op & src1[WIDTH-1];
        b_neg  = sgn_op & src2[WIDTH-1];
        a_abs  = a_neg ? (~src1 + 1'b1) : src1;
        b_abs  = b_neg ? (~src2 + 1'b1) : src2;

        // Shift-add step with carry out of the upper half kept in the shift.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        prod_fix = psign_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = psign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = rsign_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
        fa    = {a_neg ? 1'b1 : 1'b0, src1} ;
        fa    = {sgn_op & src1[WIDTH-1], src1};
        fb    = {sgn_op & src2[WIDTH-1], src2};
        fprod = fa * fb;
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        psign_d  = psign_q;
        rsign_d  = rsign_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start && run_q) begin
                    case (op)
                        MDU_MTHI: begin hi_d = src1; done_d = 1'b1; end
                        MDU_MTLO: begin lo_d = src1; done_d = 1'b1; end
                        MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            // Product is already signed; FIN just writes it.
                            acc_d    = fprod;
                            psign_d  = 1'b0;
                            rsign_d  = 1'b0;
                            is_div_d = 1'b0;
                            state_d  = FIN;
                            done_d   = 1'b1;
`else
                            acc_d    = {{WIDTH{1'b0}}, b_abs};
                            opnd_d   = a_abs;
                            psign_d  = a_neg ^ b_neg;
                            rsign_d  = a_neg;
                            is_div_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = CALC;
`endif
                        end
                        MDU_DIV, MDU_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, a_abs};
                            opnd_d   = b_abs;
                            psign_d  = a_neg ^ b_neg;
                            rsign_d  = a_neg;
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = CALC;
                        end
                        default: ;
                    endcase
                end
                CALC: begin
                    acc_d = is_div_q ? {rem_step, quo_step} : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        cnt_d   = '0;
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
                FIN: begin
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            psign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            psign_q  <= psign_d;
            rsign_q  <= rsign_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            run_q    <= 1'b1;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: inputs change on the falling edge, outputs are
// sampled on the falling edge, so each sample sees the state after one rising
// edge. Cycle c=1 is the first sample after the start edge.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src1 = '0, src2 = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    mdu_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1),
        .src2(src2), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Issue one op and observe 40 cycles: busy cycles, done pulses, first
    // done cycle, and HI/LO one cycle after done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int b_cnt, output int d_cnt, output int d_at,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        b_cnt = 0; d_cnt = 0; d_at = 0; hi_o = 'x; lo_o = 'x;
        @(negedge clk); start = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) b_cnt++;
            if (done) begin d_cnt++; if (d_at == 0) d_at = c; end
            if (d_at != 0 && c == d_at + 1) begin hi_o = hi; lo_o = lo; end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b1; op = 3'b100; src1 = 32'hDEADBEEF;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rst_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rst_lo: got %h want 0", lo); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;          // MTHI still requested across the release
        @(negedge clk);
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rel_mthi_hi: got %h want 0", hi); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rel_mthi_done: got %b want 0", done); end
        start = 1'b0;
    endtask

    task automatic test_mult;
        int bc, dc, da; logic [31:0] h, l;
        run_op(3'b000, 32'hFFFFFFFE, 32'h00000003, bc, dc, da, h, l);
        n_cmp++; if (h !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", h); end
        n_cmp++; if (l !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffa", l); end
        n_cmp++; if (bc !== MUL_LAT) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want %0d", bc, MUL_LAT); end
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL mult_done_pulses: got %0d want 1", dc); end
        n_cmp++; if (da !== MUL_LAT) begin n_bad++; $display("FAIL mult_done_cycle: got %0d want %0d", da, MUL_LAT); end
    endtask

    task automatic test_multu;
        int bc, dc, da; logic [31:0] h, l;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc, da, h, l);
        n_cmp++; if (h !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        n_cmp++; if (l !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", l); end
        n_cmp++; if (da !== MUL_LAT) begin n_bad++; $display("FAIL multu_done_cycle: got %0d want %0d", da, MUL_LAT); end
    endtask

    task automatic test_div;
        int bc, dc, da; logic [31:0] h, l;
        run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, bc, dc, da, h, l);   // -7 / 2
        n_cmp++; if (l !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", l); end
        n_cmp++; if (h !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", h); end
        n_cmp++; if (da !== DIV_LAT) begin n_bad++; $display("FAIL div_done_cycle: got %0d want %0d", da, DIV_LAT); end
        n_cmp++; if (bc !== DIV_LAT) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want %0d", bc, DIV_LAT); end
    endtask

    task automatic test_divu;
        int bc, dc, da; logic [31:0] h, l;
        run_op(3'b011, 32'd100, 32'd7, bc, dc, da, h, l);
        n_cmp++; if (l !== 32'd14) begin n_bad++; $display("FAIL divu_lo: got %h want 0000000e", l); end
        n_cmp++; if (h !== 32'd2) begin n_bad++; $display("FAIL divu_hi: got %h want 00000002", h); end
        run_op(3'b011, 32'd5, 32'd0, bc, dc, da, h, l);
        n_cmp++; if (l !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_lo: got %h want ffffffff", l); end
        n_cmp++; if (h !== 32'd5) begin n_bad++; $display("FAIL divz_hi: got %h want 00000005", h); end
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, bc, dc, da, h, l);
        n_cmp++; if (l !== 32'h80000000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", l); end
        n_cmp++; if (h !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want 00000000", h); end
    endtask

    task automatic test_reserved;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        @(negedge clk); start = 1'b1; op = 3'b110; src1 = 32'h55555555;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rsvd_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rsvd_done: got %b want 0", done); end
        n_cmp++; if ({hi, lo} !== {h0, l0}) begin n_bad++; $display("FAIL rsvd_hilo: got %h want %h", {hi, lo}, {h0, l0}); end
    endtask

    task automatic test_flush_mt;
        logic [31:0] h0, l0; int dc;
        h0 = hi; l0 = lo; dc = 0;
        @(negedge clk); start = 1'b1; op = 3'b010; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 11) flush = 1'b1;
            if (c == 12) begin
                flush = 1'b0;
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
            end
            if (done) dc++;
        end
        n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL flush_done_pulses: got %0d want 0", dc); end
        n_cmp++; if ({hi, lo} !== {h0, l0}) begin n_bad++; $display("FAIL flush_hilo: got %h want %h", {hi, lo}, {h0, l0}); end
        @(negedge clk); start = 1'b1; op = 3'b101; src1 = 32'h00001234;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (lo !== 32'h00001234) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
        n_cmp++; if (hi !== h0) begin n_bad++; $display("FAIL mtlo_hi: got %h want %h", hi, h0); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mtlo_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mtlo_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int da; logic [31:0] h, l; logic b36;
        da = 0; h = 'x; l = 'x; b36 = 1'bx;
        @(negedge clk); start = 1'b1; op = 3'b011; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5) begin start = 1'b1; op = 3'b001; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; end
            if (c == 6) start = 1'b0;
            if (done && da == 0) da = c;
            if (da != 0 && c == da + 1) begin h = hi; l = lo; end
            if (c == 36) b36 = busy;
        end
        n_cmp++; if (da !== DIV_LAT) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", da, DIV_LAT); end
        n_cmp++; if (l !== 32'd14) begin n_bad++; $display("FAIL b2b_lo: got %h want 0000000e", l); end
        n_cmp++; if (h !== 32'd2) begin n_bad++; $display("FAIL b2b_hi: got %h want 00000002", h); end
        n_cmp++; if (b36 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got %b want 0", b36); end
    endtask

    task automatic test_async_reset;
        @(negedge clk); start = 1'b1; op = 3'b010; src1 = 32'd1000; src2 = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL areset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL areset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", busy); end
        @(negedge clk); resetn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_idle: got %b want 0", busy); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL areset_hilo_after: got %h want 0", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_reserved();
        test_flush_mt();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
